// File: rtl/pipe_stage.sv
// Two-entry skid-buffered register stage for rd writeback (value, address, write enable).
// Define PIPE_STAGE_PERF_EN to add the saturating back-pressure counter stall_cnt_o.
module pipe_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] rd_val_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          rd_we_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] rd_val_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          rd_we_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CW-1:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DW-1:0] val;
    logic [AW-1:0] addr;
    logic          we;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   in_xfer;
  logic   out_xfer;

  // Handshake flags decode from registered state only.
  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign in_xfer     = in_valid_i & in_ready_o;
  assign out_xfer    = out_valid_o & out_ready_i;

  // Writes to x0 are squashed at capture; value and address are kept.
  always_comb begin
    in_entry.val  = rd_val_i;
    in_entry.addr = rd_addr_i;
    in_entry.we   = rd_we_i & (rd_addr_i != AW'(0));
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = in_entry;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d = in_entry;
          end else if (in_xfer) begin
            skid_d  = in_entry;
            state_d = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign rd_val_o  = main_q.val;
  assign rd_addr_o = main_q.addr;
  assign rd_we_o   = main_q.we & out_valid_o;

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CW-1:0] STALL_MAX = '1;

  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  // Counts cycles the head is held by downstream; saturates, ignores flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_o && !out_ready_i && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  // CW is meaningful only with stall counting; referenced here to keep the parameter live.
  if (CW == 0) begin : g_cw_unused
  end
`endif

endmodule
